vanilla_barrier_node: RTL and testbench

- Per-tile hardware barrier router, the network-side counterpart of the tile CSR barrier registers.
- Consumes the tile's Pi bit (barrier_data_o of the CSR block) and the barcfg src/dest config.
- Gathers arrival bits from the configured source directions and forwards one combined gather bit toward the dest direction.
- Returns the release bit as the tile's Po (barrier_data_i of the CSR block); when dest selects "root", the node releases its own subtree.

---
 rtl/vanilla_barrier_node.sv | 104 ++++++++++
 tb/tb_vanilla_barrier_node.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_barrier_node.sv
// rtl/vanilla_barrier_node.sv - per-tile sense-reversal barrier router with pending-cycle counter
module vanilla_barrier_node #(
    parameter int barrier_dirs_p        = 7,
    parameter int stall_counter_width_p = 32,
    localparam int barrier_lg_dirs_lp   = ((barrier_dirs_p + 1) <= 1) ? 1 : $clog2(barrier_dirs_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             pi_i,
    input  logic [barrier_dirs_p-1:0]        barrier_src_r_i,
    input  logic [barrier_lg_dirs_lp-1:0]    barrier_dest_r_i,
    input  logic [barrier_dirs_p-1:0]        gather_i,
    input  logic [barrier_dirs_p-1:0]        release_i,
    output logic                             gather_o,
    output logic                             release_o,
    output logic                             po_o,
    input  logic                             stall_clear_i,
    output logic [stall_counter_width_p-1:0] stall_count_o
);

    // Registered arrivals: bit 0 carries the local Pi, higher bits the neighbour gathers.
    logic [barrier_dirs_p-1:0]        in_r;
    logic [barrier_dirs_p-1:1]        rel_in_r;
    logic                             gather_r;
    logic                             release_r;
    logic [stall_counter_width_p-1:0] stall_count_r;

    logic                             arrived;
    logic                             dest_root;
    logic                             dest_hit;
    logic                             rel_sel;
    logic                             pending;

    // Bit 0 of the neighbour buses has no meaning; the local input is pi_i.
    logic unused_bit0;
    assign unused_bit0 = gather_i[0] ^ release_i[0];

    // Arrival detection and release-source selection from the configured directions.
    always_comb begin
        arrived   = 1'b0;
        dest_root = 1'b0;
        dest_hit  = 1'b0;
        rel_sel   = 1'b0;
        // A source has arrived once its bit differs from the current sense.
        if (barrier_src_r_i != '0) begin
            arrived = (((in_r ^ {barrier_dirs_p{gather_r}}) & barrier_src_r_i) == barrier_src_r_i);
        end
        dest_root = (barrier_dest_r_i == barrier_lg_dirs_lp'(barrier_dirs_p));
        for (int d = 1; d < barrier_dirs_p; d++) begin
            if (barrier_dest_r_i == barrier_lg_dirs_lp'(d)) begin
                dest_hit = 1'b1;
                rel_sel  = rel_in_r[d];
            end
        end
    end

    // Local barrier is outstanding while our Pi differs from the release we have seen.
    assign pending = barrier_src_r_i[0] & (in_r[0] != release_r);

    // One-hop input stage for gather and release bits.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_r     <= '0;
            rel_in_r <= '0;
        end else begin
            in_r     <= {gather_i[barrier_dirs_p-1:1], pi_i};
            rel_in_r <= release_i[barrier_dirs_p-1:1];
        end
    end

    // Gather sense flips once every selected source agrees; release follows root or dest.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            gather_r  <= 1'b0;
            release_r <= 1'b0;
        end else begin
            if (arrived) begin
                gather_r <= ~gather_r;
            end
            if (dest_root) begin
                release_r <= gather_r;
            end else if (dest_hit) begin
                release_r <= rel_sel;
            end
        end
    end

    // Saturating pending-cycle counter; clear takes priority over counting.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_count_r <= '0;
        end else if (stall_clear_i) begin
            stall_count_r <= '0;
        end else if (pending && !(&stall_count_r)) begin
            stall_count_r <= stall_count_r + stall_counter_width_p'(1);
        end
    end

    assign gather_o      = gather_r;
    assign release_o     = release_r;
    assign po_o          = release_r;
    assign stall_count_o = stall_count_r;

endmodule

// File: tb/tb_vanilla_barrier_node.sv
// tb/tb_vanilla_barrier_node.sv - directed self-checking bench for vanilla_barrier_node
module tb_vanilla_barrier_node;

    logic        clk;
    logic        reset;
    logic        pi;
    logic [6:0]  src;
    logic [2:0]  dest;
    logic [6:0]  gather_in;
    logic [6:0]  release_in;
    logic        clear;

    logic        gather_w, release_w, po_w;
    logic [31:0] count_w;
    logic        gather_n, release_n, po_n;
    logic [3:0]  count_n;

    int n_checks = 0;
    int n_errors = 0;

    vanilla_barrier_node #(.barrier_dirs_p(7), .stall_counter_width_p(32)) dut (
        .clk_i(clk), .reset_i(reset), .pi_i(pi),
        .barrier_src_r_i(src), .barrier_dest_r_i(dest),
        .gather_i(gather_in), .release_i(release_in),
        .gather_o(gather_w), .release_o(release_w), .po_o(po_w),
        .stall_clear_i(clear), .stall_count_o(count_w)
    );

    vanilla_barrier_node #(.barrier_dirs_p(7), .stall_counter_width_p(4)) dut4 (
        .clk_i(clk), .reset_i(reset), .pi_i(pi),
        .barrier_src_r_i(src), .barrier_dest_r_i(dest),
        .gather_i(gather_in), .release_i(release_in),
        .gather_o(gather_n), .release_o(release_n), .po_o(po_n),
        .stall_clear_i(clear), .stall_count_o(count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_count();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("clear_count", count_w, 32'd0);
    endtask

    initial begin
        reset = 1'b1; pi = 1'b0; src = 7'b0000001; dest = 3'd7;
        gather_in = '0; release_in = '0; clear = 1'b0;
        step(3);
        check("rst_gather", {31'd0, gather_w}, 32'd0);
        check("rst_po", {31'd0, po_w}, 32'd0);
        check("rst_release", {31'd0, release_w}, 32'd0);
        check("rst_count", count_w, 32'd0);
        reset = 1'b0;
        step(1);
        check("post_rst_po", {31'd0, po_w}, 32'd0);

        // Scenario 1: single-node root, two phases.
        pi = 1'b1;
        step(1);
        check("s1_gather_t1", {31'd0, gather_w}, 32'd0);
        step(1);
        check("s1_gather_t2", {31'd0, gather_w}, 32'd1);
        check("s1_po_t2", {31'd0, po_w}, 32'd0);
        step(1);
        check("s1_po_t3", {31'd0, po_w}, 32'd1);
        check("s1_release_t3", {31'd0, release_w}, 32'd1);
        check("s1_count", count_w, 32'd2);
        step(1);
        check("s1_count_hold", count_w, 32'd2);
        pi = 1'b0;
        step(2);
        check("s1b_gather_t2", {31'd0, gather_w}, 32'd0);
        check("s1b_po_t2", {31'd0, po_w}, 32'd1);
        step(1);
        check("s1b_po_t3", {31'd0, po_w}, 32'd0);
        check("s1b_count", count_w, 32'd4);
        clear_count();

        // Scenario 2: local plus west source; west arrives late.
        src = 7'b0000011;
        pi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("s2_po_wait", {31'd0, po_w}, 32'd0);
        end
        check("s2_gather_wait", {31'd0, gather_w}, 32'd0);
        gather_in[1] = 1'b1;
        step(2);
        check("s2_gather_t12", {31'd0, gather_w}, 32'd1);
        check("s2_po_t12", {31'd0, po_w}, 32'd0);
        step(1);
        check("s2_po_t13", {31'd0, po_w}, 32'd1);
        check("s2_count", count_w, 32'd12);
        pi = 1'b0; gather_in[1] = 1'b0;
        step(3);
        check("s2_po_back", {31'd0, po_w}, 32'd0);
        check("s2_count_back", count_w, 32'd14);
        clear_count();

        // Scenario 3: non-root, release comes from east.
        src = 7'b0000001; dest = 3'd2;
        pi = 1'b1;
        step(2);
        check("s3_gather_t2", {31'd0, gather_w}, 32'd1);
        release_in[3] = 1'b1;
        step(6);
        check("s3_po_t8", {31'd0, po_w}, 32'd0);
        release_in[2] = 1'b1;
        step(1);
        check("s3_po_t9", {31'd0, po_w}, 32'd0);
        step(1);
        check("s3_po_t10", {31'd0, po_w}, 32'd1);
        check("s3_count", count_w, 32'd9);
        release_in[3] = 1'b0;
        step(3);
        check("s3_ignore_north", {31'd0, po_w}, 32'd1);
        pi = 1'b0; release_in[2] = 1'b0;
        step(2);
        check("s3_gather_back", {31'd0, gather_w}, 32'd0);
        check("s3_po_back", {31'd0, po_w}, 32'd0);
        check("s3_count_back", count_w, 32'd10);
        clear_count();

        // Scenario 4: disabled node, then illegal dest holds release.
        src = 7'b0000000; dest = 3'd7;
        pi = 1'b1; gather_in = 7'b1111110;
        step(3);
        check("s4_gather_off", {31'd0, gather_w}, 32'd0);
        check("s4_count_off", count_w, 32'd0);
        pi = 1'b0; gather_in = '0;
        step(3);
        check("s4_gather_off2", {31'd0, gather_w}, 32'd0);
        dest = 3'd1; release_in[1] = 1'b1;
        step(2);
        check("s4_po_dest1", {31'd0, po_w}, 32'd1);
        dest = 3'd0; release_in = '0;
        step(3);
        check("s4_po_hold", {31'd0, po_w}, 32'd1);
        release_in = 7'b1111110;
        step(2);
        release_in = '0;
        step(2);
        check("s4_po_hold2", {31'd0, po_w}, 32'd1);
        dest = 3'd1;
        step(2);
        check("s4_po_restore", {31'd0, po_w}, 32'd0);
        check("s4_count", count_w, 32'd0);

        // Scenario 5: saturation of the narrow counter, clear on a pending cycle.
        src = 7'b0000001; dest = 3'd5; release_in = '0;
        pi = 1'b1;
        step(16);
        check("s5_sat_t16", {28'd0, count_n}, 32'd15);
        check("s5_wide_t16", count_w, 32'd15);
        step(4);
        check("s5_sat_t20", {28'd0, count_n}, 32'd15);
        check("s5_wide_t20", count_w, 32'd19);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("s5_clear_n", {28'd0, count_n}, 32'd0);
        check("s5_clear_w", count_w, 32'd0);
        step(1);
        check("s5_resume_n", {28'd0, count_n}, 32'd1);
        check("s5_po_stuck", {31'd0, po_w}, 32'd0);
        pi = 1'b0;
        step(3);
        check("s5_gather_back", {31'd0, gather_w}, 32'd0);

        // Scenario 6: async reset mid-barrier, then normal completion.
        dest = 3'd7;
        pi = 1'b1;
        step(2);
        check("s6_gather_pre", {31'd0, gather_w}, 32'd1);
        check("s6_po_pre", {31'd0, po_w}, 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check("s6_async_gather", {31'd0, gather_w}, 32'd0);
        check("s6_async_po", {31'd0, po_w}, 32'd0);
        check("s6_async_count", count_w, 32'd0);
        pi = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        check("s6_post_po", {31'd0, po_w}, 32'd0);
        pi = 1'b1;
        step(2);
        check("s6_gather_t2", {31'd0, gather_w}, 32'd1);
        step(1);
        check("s6_po_t3", {31'd0, po_w}, 32'd1);
        check("s6_count", count_w, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
